traffic_light_ctrl_gen: RTL and testbench



---
 rtl/traffic_light_ctrl_gen_pkg.sv | 64 ++++++
 rtl/traffic_light_ctrl_gen_phase_timer.sv | 50 +++++
 rtl/traffic_light_ctrl_gen.sv | 183 ++++++++++++++++++
 tb/tb_traffic_light_ctrl_gen.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_ctrl_gen_pkg.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl_gen_pkg
// Shared definitions for the two-road traffic light controller:
//   - FSM state encodings (also the value shown on the debug LEDs)
//   - lamp codes in {red, yellow, green} order
//   - packed lamp bundle type and the state-to-lamp decode
//   - the phase-duration range check used at elaboration
// ---------------------------------------------------------------------------
package traffic_light_ctrl_gen_pkg;

  // State encodings. Code 7 is unused and treated as illegal.
  localparam logic [2:0] ST_MAIN_G  = 3'd0;
  localparam logic [2:0] ST_MAIN_Y  = 3'd1;
  localparam logic [2:0] ST_RED_A   = 3'd2;
  localparam logic [2:0] ST_CROSS_G = 3'd3;
  localparam logic [2:0] ST_CROSS_Y = 3'd4;
  localparam logic [2:0] ST_RED_B   = 3'd5;
  localparam logic [2:0] ST_FLASH   = 3'd6;

  // Lamp codes, bit order {red, yellow, green}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Everything the lamp boards see, registered as one bundle.
  typedef struct packed {
    logic [2:0] main_st;
    logic [2:0] cross_st;
    logic       walk;
  } lamps_t;

  localparam lamps_t LAMPS_ALL_RED = '{main_st: LAMP_RED, cross_st: LAMP_RED, walk: 1'b0};

  // A duration is usable when it is at least one tick and still fits in the
  // phase counter (the counter must be able to hold dur-1).
  function automatic logic dur_in_range(input int unsigned dur, input int unsigned cnt_w);
    return (dur >= 32'd1) && (dur < (32'd1 << cnt_w));
  endfunction

  // Lamp pattern for a state. flash_lit selects the lit/dark half of the
  // flashing cycle and is ignored elsewhere. Unknown codes show all-red so a
  // corrupted state can never light a green.
  function automatic lamps_t lamp_decode(input logic [2:0] st, input logic flash_lit);
    lamps_t l;
    l = LAMPS_ALL_RED;
    case (st)
      ST_MAIN_G:  l.main_st = LAMP_GRN;
      ST_MAIN_Y:  l.main_st = LAMP_YEL;
      ST_CROSS_G: begin
        l.cross_st = LAMP_GRN;
        l.walk     = 1'b1;
      end
      ST_CROSS_Y: l.cross_st = LAMP_YEL;
      ST_FLASH: begin
        l.main_st  = flash_lit ? LAMP_YEL : LAMP_OFF;
        l.cross_st = flash_lit ? LAMP_RED : LAMP_OFF;
      end
      default: l = LAMPS_ALL_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_gen_phase_timer.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl_gen_phase_timer
// Counts 1 Hz ticks spent in the current phase.
//   clk, reset_n : system clock, asynchronous active-low reset
//   tick         : 1 Hz enable
//   clear        : restart the count (state entry); wins over tick
//   saturate     : hold at dur-1 instead of wrapping (request-mode green)
//   dur          : phase duration in ticks, 1..2^CNT_W-1
//   expired      : this tick is the last tick of the phase
//   at_limit     : counter currently holds dur-1
// ---------------------------------------------------------------------------
module traffic_light_ctrl_gen_phase_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             clear,
  input  logic             saturate,
  input  logic [CNT_W-1:0] dur,
  output logic             expired,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_sec_cnt;
  logic [CNT_W-1:0] w_last;

  assign w_last   = dur - CNT_ONE;
  assign at_limit = (r_sec_cnt == w_last);
  assign expired  = tick & at_limit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sec_cnt <= '0;
    end else if (clear) begin
      r_sec_cnt <= '0;
    end else if (tick) begin
      if (at_limit) begin
        // Saturating hold keeps the minimum green satisfied while waiting
        // for a request; otherwise wrap for the next phase.
        r_sec_cnt <= saturate ? r_sec_cnt : '0;
      end else begin
        r_sec_cnt <= r_sec_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/traffic_light_ctrl_gen.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl_gen
// Two-road intersection controller with all-red clearance, optional
// request-held main green and a night flashing mode.
//   clk         in  system clock
//   reset_n     in  asynchronous active-low reset
//   tick_1hz    in  one-clk enable pulse per second
//   ped_req     in  cross-road / pedestrian request (level or pulse)
//   flash_en    in  night/fault flashing request
//   main_st     out main lamps {red, yellow, green}
//   cross_st    out cross lamps {red, yellow, green}
//   walk        out pedestrian walk lamp
//   req_pending out latched request
//   state_o     out current state code for debug LEDs
// ---------------------------------------------------------------------------
module traffic_light_ctrl_gen
  import traffic_light_ctrl_gen_pkg::*;
#(
  parameter int unsigned CNT_W          = 5,
  parameter int unsigned MAIN_GREEN_T   = 15,
  parameter int unsigned MAIN_YELLOW_T  = 3,
  parameter int unsigned CROSS_GREEN_T  = 10,
  parameter int unsigned CROSS_YELLOW_T = 3,
  parameter int unsigned ALL_RED_T      = 1,
  parameter int unsigned REQ_MODE       = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] main_st,
  output logic [2:0] cross_st,
  output logic       walk,
  output logic       req_pending,
  output logic [2:0] state_o
);

  // Reject unusable durations when the block is elaborated.
  if (!(dur_in_range(MAIN_GREEN_T, CNT_W)   && dur_in_range(MAIN_YELLOW_T, CNT_W) &&
        dur_in_range(CROSS_GREEN_T, CNT_W)  && dur_in_range(CROSS_YELLOW_T, CNT_W) &&
        dur_in_range(ALL_RED_T, CNT_W))) begin : g_bad_duration
    $error("traffic_light_ctrl_gen: every phase duration must be within 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] DUR_MAIN_G  = CNT_W'(MAIN_GREEN_T);
  localparam logic [CNT_W-1:0] DUR_MAIN_Y  = CNT_W'(MAIN_YELLOW_T);
  localparam logic [CNT_W-1:0] DUR_CROSS_G = CNT_W'(CROSS_GREEN_T);
  localparam logic [CNT_W-1:0] DUR_CROSS_Y = CNT_W'(CROSS_YELLOW_T);
  localparam logic [CNT_W-1:0] DUR_ALL_RED = CNT_W'(ALL_RED_T);
  // FLASH advances on every tick, so its counter only ever needs to hold 0.
  localparam logic [CNT_W-1:0] DUR_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic             REQ_ON      = (REQ_MODE != 0);

  logic [2:0]       r_state;
  logic             r_flash_lit;
  logic             r_req;
  lamps_t           r_lamps;

  logic [2:0]       w_state_nxt;
  logic             w_flash_lit_nxt;
  logic             w_req_nxt;
  logic             w_enter_cross_g;
  logic             w_state_change;
  logic             w_main_g_release;
  logic [CNT_W-1:0] w_dur;
  logic             w_saturate;
  logic             w_expired;
  logic             w_at_limit;

  // ---------------------------------------------------------------------
  // Phase timer
  // ---------------------------------------------------------------------
  always_comb begin
    w_dur = DUR_ONE;
    case (r_state)
      ST_MAIN_G:  w_dur = DUR_MAIN_G;
      ST_MAIN_Y:  w_dur = DUR_MAIN_Y;
      ST_RED_A:   w_dur = DUR_ALL_RED;
      ST_CROSS_G: w_dur = DUR_CROSS_G;
      ST_CROSS_Y: w_dur = DUR_CROSS_Y;
      ST_RED_B:   w_dur = DUR_ALL_RED;
      default:    w_dur = DUR_ONE;
    endcase
  end

  assign w_saturate     = REQ_ON && (r_state == ST_MAIN_G);
  assign w_state_change = (w_state_nxt != r_state);

  traffic_light_ctrl_gen_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick_1hz),
    .clear    (w_state_change),
    .saturate (w_saturate),
    .dur      (w_dur),
    .expired  (w_expired),
    .at_limit (w_at_limit)
  );

  // In request mode the main green is a minimum: once the timer sits at its
  // limit, the next tick only leaves if a request is latched or arriving now.
  assign w_main_g_release = w_expired && (!REQ_ON || r_req || ped_req);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_flash_lit_nxt = r_flash_lit;
    case (r_state)
      ST_MAIN_G:  if (w_main_g_release) w_state_nxt = ST_MAIN_Y;
      ST_MAIN_Y:  if (w_expired)        w_state_nxt = ST_RED_A;
      // Flash requests are only honoured at the end of an all-red, so a
      // green or yellow is never cut short.
      ST_RED_A:   if (w_expired)        w_state_nxt = flash_en ? ST_FLASH : ST_CROSS_G;
      ST_CROSS_G: if (w_expired)        w_state_nxt = ST_CROSS_Y;
      ST_CROSS_Y: if (w_expired)        w_state_nxt = ST_RED_B;
      ST_RED_B:   if (w_expired)        w_state_nxt = flash_en ? ST_FLASH : ST_MAIN_G;
      ST_FLASH: begin
        if (tick_1hz) begin
          if (!flash_en) begin
            w_state_nxt = ST_RED_B;
          end else begin
            w_flash_lit_nxt = ~r_flash_lit;
          end
        end
      end
      // Illegal code recovers immediately, no tick required.
      default:    w_state_nxt = ST_RED_B;
    endcase
    // Flashing always starts on the lit half.
    if ((w_state_nxt == ST_FLASH) && (r_state != ST_FLASH)) begin
      w_flash_lit_nxt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Request latch: set by any ped_req clock, cleared when the cross green
  // that serves it begins (clear wins over a coincident request).
  // ---------------------------------------------------------------------
  assign w_enter_cross_g = (w_state_nxt == ST_CROSS_G) && (r_state != ST_CROSS_G);

  always_comb begin
    w_req_nxt = r_req;
    if (w_enter_cross_g) begin
      w_req_nxt = 1'b0;
    end else if (ped_req) begin
      w_req_nxt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // State, latch and lamp registers. Lamps load from the next-state decode
  // so they switch on the same edge as the state itself.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RED_B;
      r_flash_lit <= 1'b0;
      r_req       <= 1'b0;
      r_lamps     <= LAMPS_ALL_RED;
    end else begin
      r_state     <= w_state_nxt;
      r_flash_lit <= w_flash_lit_nxt;
      r_req       <= w_req_nxt;
      r_lamps     <= lamp_decode(w_state_nxt, w_flash_lit_nxt);
    end
  end

  assign main_st     = r_lamps.main_st;
  assign cross_st    = r_lamps.cross_st;
  assign walk        = r_lamps.walk;
  assign req_pending = r_req;
  assign state_o     = r_state;

  // Timer limit is only consumed through expired; keep it visible for probes.
  logic w_unused;
  assign w_unused = w_at_limit;

endmodule

// File: tb/tb_traffic_light_ctrl_gen.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_ctrl_gen
// Two instances share one clock: index 0 runs the fixed cycle, index 1 the
// request-held main green. A reference model tracks phase, ticks spent in
// phase and the request latch per instance; its expected output word goes
// into a queue at every rising edge and is compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_traffic_light_ctrl_gen;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n[2];
  logic       tick[2];
  logic       ped[2];
  logic       flash[2];
  logic [2:0] main_o[2];
  logic [2:0] cross_o[2];
  logic       walk_o[2];
  logic       reqp_o[2];
  logic [2:0] st_o[2];

  traffic_light_ctrl_gen #(.REQ_MODE(0)) u_fix (
    .clk (clk), .reset_n (rst_n[0]), .tick_1hz (tick[0]), .ped_req (ped[0]),
    .flash_en (flash[0]), .main_st (main_o[0]), .cross_st (cross_o[0]),
    .walk (walk_o[0]), .req_pending (reqp_o[0]), .state_o (st_o[0])
  );

  traffic_light_ctrl_gen #(.REQ_MODE(1)) u_req (
    .clk (clk), .reset_n (rst_n[1]), .tick_1hz (tick[1]), .ped_req (ped[1]),
    .flash_en (flash[1]), .main_st (main_o[1]), .cross_st (cross_o[1]),
    .walk (walk_o[1]), .req_pending (reqp_o[1]), .state_o (st_o[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase numbers are the debug codes; durations and successors come from
  // the phase table (FLASH handled separately).
  int dur_tab[7] = '{15, 3, 1, 10, 3, 1, 1};
  int nxt_tab[7] = '{1, 2, 3, 4, 5, 0, 5};

  int  m_phase[2]   = '{5, 5};
  int  m_elapsed[2] = '{0, 0};
  bit  m_req[2]     = '{0, 0};
  bit  m_lit[2]     = '{0, 0};
  bit  force_pend[2] = '{0, 0};
  bit  chk_en[2]    = '{0, 0};

  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];

  task automatic model_clk(input int d);
    int nx;
    bit done;
    if (!rst_n[d]) begin
      m_phase[d] = 5; m_elapsed[d] = 0; m_req[d] = 0; m_lit[d] = 0;
      return;
    end
    nx = m_phase[d];
    if (force_pend[d]) begin
      force_pend[d] = 0;
      nx = 5;
      m_elapsed[d] = 0;
    end else if (tick[d]) begin
      if (m_phase[d] == 6) begin
        if (!flash[d]) begin
          nx = 5;
          m_elapsed[d] = 0;
        end else begin
          m_lit[d] = !m_lit[d];
        end
      end else begin
        done = (m_elapsed[d] + 1 >= dur_tab[m_phase[d]]);
        if (d == 1 && m_phase[d] == 0 && !(m_req[d] || ped[d])) done = 0;
        if (done) begin
          nx = nxt_tab[m_phase[d]];
          if ((m_phase[d] == 2 || m_phase[d] == 5) && flash[d]) begin
            nx = 6;
            m_lit[d] = 1;
          end
          m_elapsed[d] = 0;
        end else begin
          m_elapsed[d]++;
        end
      end
    end
    if (nx == 3 && m_phase[d] != 3) m_req[d] = 0;
    else if (ped[d]) m_req[d] = 1;
    m_phase[d] = nx;
  endtask

  // {state, main, cross, walk, req_pending}
  function automatic logic [10:0] model_out(input int d);
    logic [2:0] m, c;
    logic w;
    m = 3'b100; c = 3'b100; w = 1'b0;
    case (m_phase[d])
      0: m = 3'b001;
      1: m = 3'b010;
      3: begin c = 3'b001; w = 1'b1; end
      4: c = 3'b010;
      6: begin m = m_lit[d] ? 3'b010 : 3'b000; c = m_lit[d] ? 3'b100 : 3'b000; end
      default: ;
    endcase
    return {3'(m_phase[d]), m, c, w, m_req[d]};
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      model_clk(d);
      if (chk_en[d]) begin
        if (d == 0) exp_q0.push_back(model_out(0));
        else        exp_q1.push_back(model_out(1));
      end
    end
  end

  // ---------------- scoreboard + safety invariant ----------------
  always @(negedge clk) begin : sb_blk
    logic [10:0] e;
    logic ok;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      check("scoreboard_fix", {st_o[0], main_o[0], cross_o[0], walk_o[0], reqp_o[0]}, e);
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      check("scoreboard_req", {st_o[1], main_o[1], cross_o[1], walk_o[1], reqp_o[1]}, e);
    end
    for (int d = 0; d < 2; d++) begin
      if (st_o[d] == 3'd6)
        ok = (main_o[d] == 3'b010 || main_o[d] == 3'b000) &&
             (cross_o[d] == 3'b100 || cross_o[d] == 3'b000);
      else
        ok = (main_o[d] == 3'b100) || (cross_o[d] == 3'b100);
      check(d == 0 ? "safety_fix" : "safety_req", {31'd0, ok}, 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic tick_cycle(input int d);
    tick[d] = 1'b1;
    @(posedge clk); #1;
    tick[d] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int d, input int n);
    for (int i = 0; i < n; i++) tick_cycle(d);
  endtask

  task automatic pulse_ped(input int d);
    ped[d] = 1'b1;
    @(posedge clk); #1;
    ped[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    chk_en[d] = 0;
    @(posedge clk); #1;
    rst_n[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[d] = 1'b1;
    chk_en[d] = 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ped;
    logic       flash;
    int         n;
    logic [2:0] st;
    logic [2:0] m;
    logic [2:0] c;
    logic       w;
  } vec_t;

  vec_t vecs[12];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = '{1'b0, 1'b0,  1, 3'd5, 3'b100, 3'b100, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 15, 3'd0, 3'b001, 3'b100, 1'b0};
    vecs[2]  = '{1'b0, 1'b0,  3, 3'd1, 3'b010, 3'b100, 1'b0};
    vecs[3]  = '{1'b0, 1'b0,  1, 3'd2, 3'b100, 3'b100, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 10, 3'd3, 3'b100, 3'b001, 1'b1};
    vecs[5]  = '{1'b0, 1'b0,  3, 3'd4, 3'b100, 3'b010, 1'b0};
    vecs[6]  = '{1'b0, 1'b0,  1, 3'd5, 3'b100, 3'b100, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 15, 3'd0, 3'b001, 3'b100, 1'b0};
    vecs[8]  = '{1'b0, 1'b0,  3, 3'd1, 3'b010, 3'b100, 1'b0};
    vecs[9]  = '{1'b0, 1'b0,  1, 3'd2, 3'b100, 3'b100, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 10, 3'd3, 3'b100, 3'b001, 1'b1};
    vecs[11] = '{1'b0, 1'b0,  1, 3'd4, 3'b100, 3'b010, 1'b0};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; tick[d] = 1'b0; ped[d] = 1'b0; flash[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_state", st_o[d], 3'd5);
      check("reset_lamps", {main_o[d], cross_o[d], walk_o[d], reqp_o[d]}, 8'b100_100_0_0);
      rst_n[d] = 1'b1;
      chk_en[d] = 1;
    end

    // Fixed cycle: 64 ticks from reset against the phase table.
    for (int i = 0; i < 12; i++) begin
      ped[0] = vecs[i].ped;
      flash[0] = vecs[i].flash;
      for (int k = 0; k < vecs[i].n; k++) begin
        check($sformatf("table_vec%0d", i), {st_o[0], main_o[0], cross_o[0], walk_o[0]},
              {vecs[i].st, vecs[i].m, vecs[i].c, vecs[i].w});
        tick_cycle(0);
      end
    end
    ped[0] = 1'b0;

    // Request mode: green held with no request, then released by a pulse.
    ticks(1, 1);
    ticks(1, 15);
    check("req_hold_t15", {st_o[1], main_o[1]}, {3'd0, 3'b001});
    ticks(1, 25);
    check("req_hold_t40", {st_o[1], main_o[1]}, {3'd0, 3'b001});
    pulse_ped(1);
    check("req_latched", reqp_o[1], 1'b1);
    ticks(1, 1);
    check("req_release_main_y", st_o[1], 3'd1);
    ticks(1, 4);
    check("req_cross_g", {st_o[1], walk_o[1], reqp_o[1]}, {3'd3, 1'b1, 1'b0});

    // Request mode: early request still gets the full minimum green.
    ticks(1, 14);
    check("req_back_main_g", st_o[1], 3'd0);
    ticks(1, 5);
    pulse_ped(1);
    ticks(1, 9);
    check("min_green_t14", st_o[1], 3'd0);
    ticks(1, 1);
    check("min_green_t15", st_o[1], 3'd1);

    // Flash request raised during cross green.
    do_reset(0);
    ticks(0, 20);
    check("flash_pre_cross_g", st_o[0], 3'd3);
    flash[0] = 1'b1;
    ticks(0, 10);
    check("flash_cross_y_full", st_o[0], 3'd4);
    ticks(0, 3);
    check("flash_red_b", st_o[0], 3'd5);
    ticks(0, 1);
    check("flash_enter", {st_o[0], main_o[0], cross_o[0]}, {3'd6, 3'b010, 3'b100});
    ticks(0, 1);
    check("flash_dark", {main_o[0], cross_o[0]}, {3'b000, 3'b000});
    ticks(0, 1);
    check("flash_lit_again", {main_o[0], cross_o[0]}, {3'b010, 3'b100});
    flash[0] = 1'b0;
    ticks(0, 1);
    check("flash_exit_red_b", {st_o[0], main_o[0], cross_o[0]}, {3'd5, 3'b100, 3'b100});
    ticks(0, 1);
    check("flash_exit_main_g", {st_o[0], main_o[0]}, {3'd0, 3'b001});

    // Asynchronous reset between edges in cross green.
    ticks(0, 19);
    check("areset_pre_cross_g", st_o[0], 3'd3);
    pulse_ped(0);
    check("areset_req_set", reqp_o[0], 1'b1);
    chk_en[0] = 0;
    @(posedge clk); #3;
    rst_n[0] = 1'b0;
    #1;
    check("areset_now", {st_o[0], main_o[0], cross_o[0], walk_o[0], reqp_o[0]},
          {3'd5, 3'b100, 3'b100, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    chk_en[0] = 1;

    // Illegal state code recovers on the next clock without a tick.
    ticks(0, 1);
    check("illegal_pre", st_o[0], 3'd0);
    chk_en[0] = 0;
    @(posedge clk); #1;
    force u_fix.r_state = 3'd7;
    #2;
    release u_fix.r_state;
    force_pend[0] = 1;
    @(posedge clk); #1;
    check("illegal_recover", {st_o[0], main_o[0], cross_o[0]}, {3'd5, 3'b100, 3'b100});
    chk_en[0] = 1;
    ticks(0, 1);
    check("illegal_then_main_g", st_o[0], 3'd0);

    // Randomised traffic on both instances, checked by the scoreboard.
    for (int i = 0; i < 4000; i++) begin
      for (int d = 0; d < 2; d++) begin
        tick[d] = !tick[d] && ($urandom_range(0, 2) == 0);
        ped[d]  = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 99) == 0) flash[d] = !flash[d];
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      tick[d] = 1'b0; ped[d] = 1'b0; flash[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
